// File: rtl/dtree_io_pkg.sv
// Shared types and default sizes for the decision-tree stream adapter.
//   state_t      : adapter control states
//   NUM_FEATURES : feature bytes per frame
//   FEAT_W       : bits per feature
//   CLASS_W      : class width produced by the tree
//   CNT_W        : accepted-result counter width
//   SETTLE_CYCLES: cycles the feature vector is held before class capture
package dtree_io_pkg;

  localparam int unsigned NUM_FEATURES  = 138;
  localparam int unsigned FEAT_W        = 8;
  localparam int unsigned CLASS_W       = 3;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/dtree_feat_assembler.sv
// Indexed feature register bank: writes one feature per enabled cycle at
// slot idx and advances idx; idx_clr returns idx to slot 0 (a write in the
// same cycle still lands at the current slot).
//   clk, rst   : clock, synchronous active-high reset (clears bank and idx)
//   wr_en      : write wr_data to slot idx and advance idx
//   idx_clr    : frame boundary, idx back to 0
//   wr_data    : feature byte
//   feat_vec   : parallel feature vector, slot i at [i*FEAT_W +: FEAT_W]
//   idx        : current write slot
//   idx_last_c : idx is the final slot (combinational decode of idx)
module dtree_feat_assembler #(
  parameter  int unsigned NUM_FEATURES = 138,
  parameter  int unsigned FEAT_W       = 8,
  localparam int unsigned IDX_W        = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic                           idx_clr,
  input  logic [FEAT_W-1:0]              wr_data,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_vec,
  output logic [IDX_W-1:0]               idx,
  output logic                           idx_last_c
);

  assign idx_last_c = (idx == IDX_W'(NUM_FEATURES - 1));

  // Write pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (idx_clr) begin
      idx <= '0;
    end else if (wr_en) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Feature bank
  always_ff @(posedge clk) begin
    if (rst) begin
      feat_vec <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_FEATURES; i++) begin
        if (idx == IDX_W'(i)) begin
          feat_vec[i*FEAT_W +: FEAT_W] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/dtree_stream_adapter.sv
// Streaming wrapper around the combinational decision tree: assembles a
// frame of feature bytes into feat_vec, holds it for SETTLE_CYCLES, captures
// the tree's class and offers it on a valid/ready result stream.
//   clk, rst           : clock, synchronous active-high reset
//   s_valid/s_ready    : feature byte handshake
//   s_data, s_last     : feature byte, end-of-frame marker
//   feat_vec           : parallel features to the tree
//   class_in           : tree output (combinational from feat_vec)
//   m_valid/m_ready    : result handshake
//   m_class            : captured class
//   err_frame          : one-cycle pulse on frame length mismatch
//   frame_count        : results accepted downstream (wrapping)
module dtree_stream_adapter #(
  parameter int unsigned NUM_FEATURES  = dtree_io_pkg::NUM_FEATURES,
  parameter int unsigned FEAT_W        = dtree_io_pkg::FEAT_W,
  parameter int unsigned CLASS_W       = dtree_io_pkg::CLASS_W,
  parameter int unsigned SETTLE_CYCLES = dtree_io_pkg::SETTLE_CYCLES,
  parameter int unsigned CNT_W         = dtree_io_pkg::CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [FEAT_W-1:0]              s_data,
  input  logic                           s_last,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_vec,
  input  logic [CLASS_W-1:0]             class_in,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CLASS_W-1:0]             m_class,
  output logic                           err_frame,
  output logic [CNT_W-1:0]               frame_count
);

  import dtree_io_pkg::*;

  localparam int unsigned IDX_W  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned SCNT_W = 4;

  state_t              state;
  state_t              state_next;
  logic [SCNT_W-1:0]   settle_cnt;
  logic [IDX_W-1:0]    idx;
  logic                idx_last_c;
  logic                beat;
  logic                settle_done;
  logic                wr_en;
  logic                idx_clr;
  logic                err_set;
  logic                capture;
  logic                res_xfer;

  assign beat        = s_valid && s_ready;
  assign settle_done = (settle_cnt == SCNT_W'(SETTLE_CYCLES - 1));

  dtree_feat_assembler #(
    .NUM_FEATURES (NUM_FEATURES),
    .FEAT_W       (FEAT_W)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .idx_clr    (idx_clr),
    .wr_data    (s_data),
    .feat_vec   (feat_vec),
    .idx        (idx),
    .idx_last_c (idx_last_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      LOAD:    if (beat && idx_last_c) state_next = s_last ? SETTLE : DRAIN;
      DRAIN:   if (beat && s_last)     state_next = LOAD;
      SETTLE:  if (settle_done)        state_next = OUT;
      OUT:     if (m_valid && m_ready) state_next = LOAD;
      default:                         state_next = LOAD;
    endcase
  end

  // Control decode
  always_comb begin
    wr_en    = 1'b0;
    idx_clr  = 1'b0;
    err_set  = 1'b0;
    capture  = 1'b0;
    res_xfer = 1'b0;
    unique case (state)
      LOAD: begin
        wr_en   = beat;
        // Frame ends on s_last or on the final slot; mismatch of the two is an error
        idx_clr = beat && (s_last || idx_last_c);
        err_set = beat && (s_last ^ idx_last_c);
      end
      SETTLE:  capture  = settle_done;
      OUT:     res_xfer = m_valid && m_ready;
      default: ;
    endcase
  end

  // Input ready follows the state being entered, so it is a clean flop output
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready <= 1'b1;
    end else begin
      s_ready <= (state_next == LOAD) || (state_next == DRAIN);
    end
  end

  // Settle timer, result register, error pulse, accepted-result counter
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt  <= '0;
      m_valid     <= 1'b0;
      m_class     <= '0;
      err_frame   <= 1'b0;
      frame_count <= '0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + SCNT_W'(1) : '0;
      // Back-to-back one-byte frames would otherwise hold err_frame high
      err_frame  <= err_set && !err_frame;
      if (capture) begin
        m_class <= class_in;
        m_valid <= 1'b1;
      end else if (res_xfer) begin
        m_valid <= 1'b0;
      end
      if (res_xfer) begin
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dtree_stream_adapter.sv
// Self-checking bench for dtree_stream_adapter: frame table plus hand-written
// backpressure, reset and counter-wrap sequences, with a result scoreboard.
module tb_dtree_stream_adapter;

  localparam int unsigned NF = 138;
  localparam int unsigned FW = 8;
  localparam int unsigned CW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [FW-1:0]   s_data = '0;
  logic            s_last = 1'b0;
  logic [NF*FW-1:0] feat_vec;
  logic [CW-1:0]   class_in;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [CW-1:0]   m_class;
  logic            err_frame;
  logic [15:0]     frame_count;

  logic            s_ready_w;
  logic [NF*FW-1:0] feat_vec_w;
  logic [CW-1:0]   class_in_w;
  logic            m_valid_w;
  logic [CW-1:0]   m_class_w;
  logic            err_frame_w;
  logic [3:0]      frame_count_w;

  logic            force_en = 1'b0;
  logic [CW-1:0]   force_val = '0;
  logic            mr_rand = 1'b0;
  logic            mr_val = 1'b1;

  int              n_vec = 0;
  int              n_bad = 0;
  int              err_cnt = 0;
  int              res_cnt = 0;
  logic            err_prev = 1'b0;
  logic            held_v = 1'b0;
  logic [CW-1:0]   held_class = '0;
  int              exp_fc = 0;
  logic [CW-1:0]   exp_q[$];
  logic [NF*FW-1:0] exp_fv = '0;

  typedef struct {
    int unsigned nbytes;
    logic [7:0]  seed;
    bit          gaps;
    int          exp_err;
    int          exp_res;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  // Stand-in for the tree: a fixed function of a few feature slots
  function automatic logic [CW-1:0] tree(input logic [NF*FW-1:0] fv);
    logic [7:0] a, b, c, d;
    a = fv[0 +: 8];
    b = fv[69*8 +: 8];
    c = fv[137*8 +: 8];
    d = fv[5*8 +: 8];
    return 3'(a + b + c + (d >> 5));
  endfunction

  function automatic logic [7:0] byte_of(input logic [7:0] seed, input int i);
    return 8'(i + int'(seed) * 13);
  endfunction

  assign class_in   = force_en ? force_val : tree(feat_vec);
  assign class_in_w = tree(feat_vec_w);

  dtree_stream_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .feat_vec    (feat_vec),
    .class_in    (class_in),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_class     (m_class),
    .err_frame   (err_frame),
    .frame_count (frame_count)
  );

  dtree_stream_adapter #(.CNT_W(4)) dut_w (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready_w),
    .s_data      (s_data),
    .s_last      (s_last),
    .feat_vec    (feat_vec_w),
    .class_in    (class_in_w),
    .m_valid     (m_valid_w),
    .m_ready     (m_ready),
    .m_class     (m_class_w),
    .err_frame   (err_frame_w),
    .frame_count (frame_count_w)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result ready driver, updated just after each rising edge
  always @(posedge clk) begin
    #2;
    m_ready = mr_rand ? 1'($urandom) : mr_val;
  end

  // Output monitor and scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (err_frame) begin
        err_cnt++;
        chk("err_not_consecutive", 64'(err_prev), 64'd0);
      end
      err_prev = err_frame;
      if (m_valid) begin
        if (held_v) chk("m_class_stable", 64'(m_class), 64'(held_class));
        held_v     = !m_ready;
        held_class = m_class;
      end else begin
        held_v = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          chk("m_class", 64'(m_class), 64'(exp_q.pop_front()));
        end
        chk("frame_count_at_xfer", 64'(frame_count), 64'(16'(exp_fc)));
        exp_fc++;
        res_cnt++;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input bit gaps, output int stalls);
    stalls = 0;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      stalls++;
      if (stalls > 500) begin
        chk("beat_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] seed, input int nbytes, input int start,
                            input bit gaps, input bit push);
    logic [7:0] d;
    int         st;
    for (int i = start; i < nbytes; i++) begin
      d = byte_of(seed, i);
      if (i < int'(NF)) exp_fv[i*FW +: FW] = d;
      if (i == nbytes - 1 && push) exp_q.push_back(force_en ? force_val : tree(exp_fv));
      send_beat(d, 1'(i == nbytes - 1), gaps, st);
    end
  endtask

  task automatic wait_mvalid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid && lat < 50);
    if (!m_valid) chk("m_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    exp_q.delete();
    exp_fc  = 0;
    @(negedge clk);
    chk({tag, "_s_ready"},  64'(s_ready), 64'd1);
    chk({tag, "_m_valid"},  64'(m_valid), 64'd0);
    chk({tag, "_feat_zero"}, 64'(feat_vec == '0), 64'd1);
    chk({tag, "_fcount"},   64'(frame_count), 64'd0);
    chk({tag, "_err"},      64'(err_frame), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, st, e0, r0;

    tbl[0] = '{138, 8'd0,   1'b0, 0, 1};
    tbl[1] = '{41,  8'd3,   1'b0, 1, 0};   // short: s_last on index 40
    tbl[2] = '{138, 8'd7,   1'b0, 0, 1};
    tbl[3] = '{143, 8'd9,   1'b0, 1, 0};   // long: 5 extra bytes
    tbl[4] = '{138, 8'd11,  1'b0, 0, 1};
    tbl[5] = '{138, 8'h55,  1'b1, 0, 1};
    tbl[6] = '{1,   8'd17,  1'b0, 1, 0};   // s_last on index 0
    tbl[7] = '{137, 8'd19,  1'b0, 1, 0};   // one byte short
    tbl[8] = '{139, 8'd23,  1'b0, 1, 0};   // one byte long
    tbl[9] = '{138, 8'hA0,  1'b1, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Nominal frame with a forced class and free-running m_ready
    force_en = 1'b1; force_val = 3'd5; mr_rand = 1'b0; mr_val = 1'b1;
    e0 = err_cnt; r0 = res_cnt;
    send_frame(8'd0, NF, 0, 1'b0, 1'b1);
    wait_mvalid(lat);
    chk("nominal_latency", 64'(lat), 64'd3);
    chk("nominal_slot0",   64'(feat_vec[0 +: 8]), 64'h00);
    chk("nominal_slot137", 64'(feat_vec[137*8 +: 8]), 64'h89);
    chk("nominal_m_class", 64'(m_class), 64'd5);
    wait_drain();
    chk("nominal_fcount", 64'(frame_count), 64'd1);
    chk("nominal_err",    64'(err_cnt - e0), 64'd0);
    chk("nominal_res",    64'(res_cnt - r0), 64'd1);
    force_en = 1'b0;

    // Frame table
    for (int k = 0; k < 10; k++) begin
      mr_rand = tbl[k].gaps;
      e0 = err_cnt; r0 = res_cnt;
      send_frame(tbl[k].seed, int'(tbl[k].nbytes), 0, tbl[k].gaps, 1'(tbl[k].exp_res));
      wait_drain();
      chk($sformatf("tbl%0d_err", k), 64'(err_cnt - e0), 64'(tbl[k].exp_err));
      chk($sformatf("tbl%0d_res", k), 64'(res_cnt - r0), 64'(tbl[k].exp_res));
    end

    // Backpressure with the next frame's first byte held valid
    mr_rand = 1'b0; mr_val = 1'b0;
    r0 = res_cnt;
    send_frame(8'd21, NF, 0, 1'b0, 1'b1);
    wait_mvalid(lat);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = byte_of(8'd22, 0); s_last = 1'b0;
    exp_fv[0 +: FW] = byte_of(8'd22, 0);
    repeat (10) begin
      @(negedge clk);
      chk("bp_s_ready", 64'(s_ready), 64'd0);
      chk("bp_m_valid", 64'(m_valid), 64'd1);
      @(posedge clk); #1;
    end
    mr_val = 1'b1;
    send_beat(byte_of(8'd22, 0), 1'b0, 1'b0, st);
    chk("bp_first_beat_stalls", 64'(st), 64'd1);
    send_frame(8'd22, NF, 1, 1'b0, 1'b1);
    wait_drain();
    chk("bp_res", 64'(res_cnt - r0), 64'd2);

    // Reset in the middle of a frame
    for (int i = 0; i < 70; i++) send_beat(byte_of(8'd30, i), 1'b0, 1'b0, st);
    do_reset("rst_mid");
    r0 = res_cnt;
    send_frame(8'd31, NF, 0, 1'b0, 1'b1);
    wait_drain();
    chk("rst_mid_res",    64'(res_cnt - r0), 64'd1);
    chk("rst_mid_fcount", 64'(frame_count), 64'd1);

    // Reset while a result is pending
    mr_val = 1'b0;
    send_frame(8'd33, NF, 0, 1'b0, 1'b1);
    wait_mvalid(lat);
    @(posedge clk); #1;
    do_reset("rst_out");
    mr_val = 1'b1;
    r0 = res_cnt;
    send_frame(8'd34, NF, 0, 1'b0, 1'b1);
    wait_drain();
    chk("rst_out_res", 64'(res_cnt - r0), 64'd1);

    // Counter wrap on a 4-bit instance, with input gaps and random m_ready
    do_reset("rst_wrap");
    mr_rand = 1'b1;
    r0 = res_cnt;
    for (int f = 0; f < 16; f++) begin
      send_frame(8'(40 + f), NF, 0, 1'b1, 1'b1);
    end
    wait_drain();
    mr_rand = 1'b0;
    chk("wrap_res",      64'(res_cnt - r0), 64'd16);
    chk("wrap_fcount16", 64'(frame_count), 64'd16);
    chk("wrap_fcount4",  64'(frame_count_w), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
